// File: rtl/adam_tag_mem_ctrl.sv
// Round-robin arbiter/sequencer in front of the single-port DIFT tag memory, with an optional
// bulk-clear engine built only when ADAM_TAG_CLR_EN is defined (otherwise the arbiter is always active).
module adam_tag_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int SIZE       = 4096,
    parameter int CNT_WIDTH  = $clog2(SIZE / STRB_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  p0_req_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic                  p0_we_i,
    input  logic [STRB_WIDTH-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0] p0_wdata_i,
    output logic                  p0_gnt_o,
    output logic                  p0_rvalid_o,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,

    input  logic                  p1_req_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic                  p1_we_i,
    input  logic [STRB_WIDTH-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0] p1_wdata_i,
    output logic                  p1_gnt_o,
    output logic                  p1_rvalid_o,
    output logic [DATA_WIDTH-1:0] p1_rdata_o,

    input  logic                  clr_start_i,
    input  logic [ADDR_WIDTH-1:0] clr_base_i,
    input  logic [CNT_WIDTH-1:0]  clr_len_i,
    input  logic [DATA_WIDTH-1:0] clr_value_i,
    output logic                  clr_busy_o,
    output logic                  clr_done_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [STRB_WIDTH-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    logic                  rr_q, rr_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic                  rsp_sel_q, rsp_sel_d;
    logic                  arb_en;
    logic                  gnt_any;
    logic                  gnt_sel;
    logic                  clr_active;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] clr_wdata;

`ifdef ADAM_TAG_CLR_EN
    localparam int ALIGNED_SIZE = SIZE / STRB_WIDTH;
    localparam int OFFS         = $clog2(STRB_WIDTH);
    localparam int PTR_W        = ADDR_WIDTH - OFFS;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d, ptr_inc;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic                  done_q, done_d;
    logic                  unused_base_lsb;

    assign unused_base_lsb = ^clr_base_i[OFFS-1:0];
    assign ptr_inc         = ptr_q + 1'b1;

    // A zero-length clear only pulses done; otherwise the cnt==1 write is the last one.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (clr_start_i) begin
                if (clr_len_i == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = CLEAR;
                    ptr_d   = clr_base_i[ADDR_WIDTH-1:OFFS];
                    cnt_d   = clr_len_i;
                    value_d = clr_value_i;
                end
            end
        end else begin
            ptr_d = (ptr_inc >= PTR_W'(ALIGNED_SIZE)) ? '0 : ptr_inc;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_WIDTH'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

    assign clr_active = (state_q == CLEAR) && !rst_i;
    assign clr_addr   = {ptr_q, {OFFS{1'b0}}};
    assign clr_wdata  = value_q;
    assign arb_en     = (state_q == IDLE) && !clr_start_i && !rst_i;
    assign clr_busy_o = (state_q == CLEAR);
    assign clr_done_o = done_q;
`else
    logic unused_clr;

    assign unused_clr = ^{clr_start_i, clr_base_i, clr_len_i, clr_value_i};
    assign clr_active = 1'b0;
    assign clr_addr   = '0;
    assign clr_wdata  = '0;
    assign arb_en     = !rst_i;
    assign clr_busy_o = 1'b0;
    assign clr_done_o = 1'b0;
`endif

    // When both ports request, rr_q names the port whose turn it is.
    always_comb begin
        gnt_any   = arb_en && (p0_req_i || p1_req_i);
        gnt_sel   = (p0_req_i && p1_req_i) ? rr_q : p1_req_i;
        rr_d      = gnt_any ? ~gnt_sel : rr_q;
        rsp_vld_d = gnt_any;
        rsp_sel_d = gnt_sel;
    end

    assign p0_gnt_o = gnt_any && !gnt_sel;
    assign p1_gnt_o = gnt_any && gnt_sel;

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (clr_active) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = clr_addr;
            mem_be_o    = '1;
            mem_wdata_o = clr_wdata;
        end else if (gnt_any) begin
            mem_req_o   = 1'b1;
            mem_we_o    = gnt_sel ? p1_we_i    : p0_we_i;
            mem_addr_o  = gnt_sel ? p1_addr_i  : p0_addr_i;
            mem_be_o    = gnt_sel ? p1_be_i    : p0_be_i;
            mem_wdata_o = gnt_sel ? p1_wdata_i : p0_wdata_i;
        end
    end

    // The response pipeline runs regardless of the clear engine so in-flight grants still answer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q      <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_sel_q <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_sel_q <= rsp_sel_d;
        end
    end

    assign p0_rvalid_o = rsp_vld_q && !rsp_sel_q;
    assign p1_rvalid_o = rsp_vld_q && rsp_sel_q;
    assign p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : '0;
    assign p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : '0;

endmodule
